mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store controller between the pipeline MEM stage and the byte-addressed data memory (mem).
//  Accepts one load/store request at a time on a valid/ready handshake and drives mem's memRead,
//  memWrite, address and dataIn. Captures dataOut, which mem delivers one cycle after memRead.
//  Adds byte loads (sign/zero-extend), byte stores (read-modify-write) and misalign/range errors.
// PARAMETERS
//  ADDR_W     16   request and memory address width
//  DATA_W     16   word width; only 16 is supported (two 8-bit lanes)
//  MEM_BYTES  128  byte capacity of mem; any address >= MEM_BYTES is out of range
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, synchronous, active-low
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept (IDLE state)
//  req_write  in   1       1=store, 0=load
//  req_byte   in   1       1=byte access, 0=word access
//  req_signed in   1       byte load only: 1=sign-extend, 0=zero-extend
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   DATA_W  store data; byte store uses [7:0]
//  rsp_valid  out  1       one-cycle completion pulse (load data or store ack)
//  rsp_err    out  1       qualifies rsp_valid: misaligned or out-of-range, no memory access made
//  rsp_rdata  out  DATA_W  load result; 0 for stores and errors
//  memRead    out  1       to mem: latch read address at this edge
//  memWrite   out  1       to mem: write {dataIn} at address, address+1 at this edge
//  address    out  ADDR_W  to mem: word address, always even
//  dataIn     out  DATA_W  to mem: write word
//  dataOut    in   DATA_W  from mem: word at latched address, big-endian (even byte = [15:8])
// BEHAVIOUR
//  - Reset (rst=0 at an edge): state<=IDLE; rsp_valid,rsp_err<=0; rsp_rdata,address,dataIn<=0.
//    memRead/memWrite forced 0 in every cycle rst=0. req_ready=0 while rst=0, 1 after release.
//  - Accept on edge with req_valid&&req_ready. Request fields are registered; inputs are ignored
//    after that edge. req_ready = (state==IDLE).
//  - Check at accept: err if (!req_byte && req_addr[0]) or req_addr>=MEM_BYTES -> state ERR.
//    ERR: no mem strobe; edge k+1: rsp_valid=1, rsp_err=1, rsp_rdata=0; go IDLE.
//  - address = {req_addr[ADDR_W-1:1],1'b0} for all accesses.
//  - Word store: WR state (memWrite=1, dataIn=wdata); edge k+1 mem writes, rsp_valid pulse; IDLE.
//  - Load: RD (memRead=1) -> CAP (dataOut valid) -> edge k+2 rsp_rdata<=extracted, rsp_valid=1; IDLE.
//    Word: dataOut. Byte even: lane [15:8], odd: lane [7:0]; extend per req_signed.
//  - Byte store: RD -> CAP (edge: merge wdata[7:0] into the addressed lane of dataOut, keep other
//    lane) -> WR (memWrite=1, merged word) -> edge k+3 rsp_valid pulse; IDLE.
//  - Latency from accept edge k: err k+1, word store k+1, load k+2, byte store k+3.
//  - Strobes are Moore-decoded from state; memRead and memWrite are never high together.
//  - A new request may be accepted at the edge that raises rsp_valid (state already IDLE).
//  - Reset mid-operation: op dropped, no rsp_valid; a byte store interrupted before WR never writes.
//  - Address wrap: address+1 never crosses MEM_BYTES, because word addresses are forced even.
// STRUCTURE
//  - Package mem_ctrl_pkg: state enum {IDLE,ERR,RD,CAP,WR}, lane select constants LANE_HI/LANE_LO.
//  - One sub-module byte_lane_unit (combinational): extract+extend for loads, lane merge for stores.
//  - Top holds the FSM, the request/merge registers and the response registers.
// TESTING
//  1. Word store 0x1234 @0x0010, then word load @0x0010 -> rsp_rdata=0x1234, rsp_valid at k+2.
//  2. Byte store 0xCD @0x0011 over 0x1234 -> word load @0x0010 =0x12CD; ack at k+3, 1 memWrite.
//  3. Byte loads @0x0011 signed->0xFFCD, unsigned->0x00CD; @0x0010 signed->0x0012.
//  4. Word load @0x0003 and @0x0080 -> rsp_err=1, rsp_rdata=0 at k+1; memRead/memWrite stay 0.
//  5. rst=0 during CAP of byte store @0x0010 -> no memWrite, no rsp_valid, word unchanged,
//     req_ready=1 first cycle after release.
//  6. After mem reset, back-to-back word loads @0x0000, @0x0000 with req_valid held -> 0xAB99 twice;
//     second accepted on first rsp_valid edge.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the load/store controller and its byte-lane datapath.
package mem_ctrl_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    WR   = 3'd4
  } state_e;

  // Lane select is the byte address LSB; memory words are big-endian.
  localparam logic LANE_HI = 1'b0;
  localparam logic LANE_LO = 1'b1;

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane datapath: byte extract/extend for loads and lane merge for byte stores.
module byte_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic              lane_i,
  input  logic              byte_i,
  input  logic              signed_i,
  input  logic [LANE_W-1:0] wbyte_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merge_o
);

  logic [LANE_W-1:0] sel;
  logic [LANE_W-1:0] ext;

  always_comb begin
    sel     = (lane_i == LANE_HI) ? word_i[WORD_W-1:LANE_W] : word_i[LANE_W-1:0];
    ext     = {LANE_W{signed_i & sel[LANE_W-1]}};
    load_o  = byte_i ? {ext, sel} : word_i;
    merge_o = (lane_i == LANE_HI) ? {wbyte_i, word_i[LANE_W-1:0]}
                                  : {word_i[WORD_W-1:LANE_W], wbyte_i};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the MEM stage and a byte-addressed word memory with
// one-cycle read latency; adds byte loads/stores (read-modify-write) and access checks.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataOut
);

  state_e              state_q, state_d;
  logic                lane_q, lane_d;
  logic                byte_q, byte_d;
  logic                signed_q, signed_d;
  logic                write_q, write_d;
  logic [LANE_W-1:0]   wbyte_q, wbyte_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                accept;
  logic                req_bad;
  logic [DATA_W-1:0]   load_word;
  logic [DATA_W-1:0]   merge_word;

  byte_lane_unit u_lane (
    .word_i   (dataOut),
    .lane_i   (lane_q),
    .byte_i   (byte_q),
    .signed_i (signed_q),
    .wbyte_i  (wbyte_q),
    .load_o   (load_word),
    .merge_o  (merge_word)
  );

  assign accept  = req_valid && (state_q == IDLE);
  assign req_bad = (!req_byte && req_addr[0]) || (req_addr >= ADDR_W'(MEM_BYTES));

  // Next-state and register updates; response flags default low so they pulse.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    byte_d      = byte_q;
    signed_d    = signed_q;
    write_d     = write_q;
    wbyte_d     = wbyte_q;
    address_d   = address_q;
    data_in_d   = data_in_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          lane_d   = req_addr[0];
          byte_d   = req_byte;
          signed_d = req_signed;
          write_d  = req_write;
          wbyte_d  = req_wdata[LANE_W-1:0];
          if (req_bad) begin
            state_d = ERR;
          end else begin
            address_d = {req_addr[ADDR_W-1:1], 1'b0};
            if (req_write && !req_byte) begin
              data_in_d = req_wdata;
              state_d   = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
        state_d     = IDLE;
      end
      RD: state_d = CAP;
      CAP: begin
        if (write_q) begin
          data_in_d = merge_word;
          state_d   = WR;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_word;
          state_d     = IDLE;
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      lane_q      <= 1'b0;
      byte_q      <= 1'b0;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      wbyte_q     <= '0;
      address_q   <= '0;
      data_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      byte_q      <= byte_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      wbyte_q     <= wbyte_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Strobes decode straight from state and are gated by reset so they drop in the reset cycle.
  assign memRead   = rst && (state_q == RD);
  assign memWrite  = rst && (state_q == WR);
  assign req_ready = rst && (state_q == IDLE);

  assign address   = address_q;
  assign dataIn    = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural memory, request table, response scoreboard.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned MB = 128;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_byte, req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          memRead, memWrite;
  logic [AW-1:0] address;
  logic [DW-1:0] dataIn, dataOut;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rd_cnt      = 0;
  int wr_cnt      = 0;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic        w;
    logic        b;
    logic        s;
    logic [15:0] a;
    logic [15:0] d;
    logic        err;
    logic [15:0] rdata;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] mem [MB];
  logic [6:0] rd_addr = '0;
  logic       mem_clr;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_byte   (req_byte),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .address    (address),
    .dataIn     (dataIn),
    .dataOut    (dataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: big-endian word over two bytes, read data one cycle after memRead.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
      mem[0] <= 8'hAB;
      mem[1] <= 8'h99;
    end else if (memWrite) begin
      mem[address[6:0]]        <= dataIn[15:8];
      mem[address[6:0] + 7'd1] <= dataIn[7:0];
    end
    if (memRead) rd_addr <= address[6:0];
  end
  assign dataOut = {mem[rd_addr], mem[rd_addr + 7'd1]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor and strobe sanity, sampled on the falling edge.
  always @(negedge clk) begin
    if (memRead) rd_cnt++;
    if (memWrite) wr_cnt++;
    if (memRead && memWrite) begin
      miscompares++;
      $display("FAIL strobe_excl: memRead and memWrite both high at t=%0t", $time);
    end
    if ((memRead || memWrite) && (address[0] || address >= 16'(MB))) begin
      miscompares++;
      $display("FAIL strobe_addr: got address %h, expected even and below %0d", address, MB);
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 err=%b rdata=%h, expected none", rsp_err, rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
        chk("rsp_edge", 32'(cyc - 1), 32'(mon_e.due));
      end
    end
  end

  function automatic vec_t mk(input logic w, input logic b, input logic s, input logic [15:0] a,
                              input logic [15:0] d, input logic e, input logic [15:0] r, input int lat);
    vec_t v;
    v = '{w, b, s, a, d, e, r, lat};
    return v;
  endfunction

  task automatic do_req(input vec_t v);
    int n;
    int k;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: got req_ready=0, expected 1 within 20 cycles");
      return;
    end
    req_valid = 1'b1; req_write = v.w; req_byte = v.b; req_signed = v.s;
    req_addr = v.a; req_wdata = v.d;
    @(posedge clk);
    k = cyc;
    sb.push_back('{v.err, v.rdata, k + v.lat});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 16'hDEAD;
    req_wdata = 16'hF00D;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rsp_timeout: got %0d pending responses, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rd0, wr0, erd, ewr, k0, n;
    vec_t v;
    rst = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_dataIn", 32'(dataIn), 32'd0);
    chk("rst_strobes", 32'({memRead, memWrite}), 32'd0);
    rst = 1'b1; mem_clr = 1'b0;
    #1 chk("rel_ready", 32'(req_ready), 32'd1);

    //         w     b     s     addr      wdata     err   rdata     lat
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 1'b0, 16'h0000, 1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234, 2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0011, 16'hAACD, 1'b0, 16'h0000, 3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h12CD, 2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 1'b0, 16'hFFCD, 2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 16'h00CD, 2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0012, 2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0000, 1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0080, 16'h0000, 1'b1, 16'h0000, 1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0010, 16'h3385, 1'b0, 16'h0000, 3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h85CD, 2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'hFF85, 2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0085, 2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 16'h007F, 16'h005A, 1'b0, 16'h0000, 3));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h007E, 16'h0000, 1'b0, 16'h005A, 2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 1'b1, 16'h0000, 1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0081, 16'hBEEF, 1'b1, 16'h0000, 1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h7777, 1'b1, 16'h0000, 1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hAB99, 2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 16'hFF99, 2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 16'h007E, 16'hC3A5, 1'b0, 16'h0000, 1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 16'h007E, 16'h0000, 1'b0, 16'hC3A5, 2));

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.err) begin erd = 0; ewr = 0; end
      else if (!v.w) begin erd = 1; ewr = 0; end
      else if (!v.b) begin erd = 0; ewr = 1; end
      else begin erd = 1; ewr = 1; end
      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(v);
      wait_idle();
      chk($sformatf("vec%0d_memRead_cnt", i), 32'(rd_cnt - rd0), 32'(erd));
      chk($sformatf("vec%0d_memWrite_cnt", i), 32'(wr_cnt - wr0), 32'(ewr));
    end

    // Reset while a byte store sits in CAP: nothing written, no response.
    wr0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0010; req_wdata = 16'h0011;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_strobes", 32'({memRead, memWrite}), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_ready_after", 32'(req_ready), 32'd1);
    chk("midrst_no_write", 32'(wr_cnt - wr0), 32'd0);
    do_req(mk(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h85CD, 2));
    wait_idle();

    // Memory reset, then two word loads with req_valid held throughout.
    @(negedge clk);
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000;
    @(posedge clk);
    k0 = cyc;
    sb.push_back('{1'b0, 16'hAB99, k0 + 2});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 10);
    chk("b2b_rsp_with_ready", 32'(rsp_valid), 32'd1);
    chk("b2b_ready_edge", 32'(cyc - 1), 32'(k0 + 2));
    @(posedge clk);
    sb.push_back('{1'b0, 16'hAB99, cyc + 2});
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
